// File: rtl/adc_sample_fifo.sv
// Synchronous sample FIFO behind the VCO-ADC decimator: buffers decimated words for a slower host reader
// and reports fill level, a threshold interrupt and sticky overflow with a saturating drop count.
module adc_sample_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  rd_en_in,
    input  logic                  clear_in,
    input  logic [DEPTH_LOG2:0]   threshold_in,
    output logic [DATA_WIDTH-1:0] rd_data_out,
    output logic                  rd_valid_out,
    output logic                  empty_out,
    output logic                  full_out,
    output logic [DEPTH_LOG2:0]   level_out,
    output logic                  irq_out,
    output logic                  overflow_out,
    output logic [15:0]           drop_cnt_out
);
    localparam int unsigned LW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = 16;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LW-1:0]         level;
    logic [LW-1:0]         level_nxt;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  drop;

    // Flags come from the registered level only, so no input reaches an output combinationally.
    assign empty_out = (level == '0);
    assign full_out  = (level == LW'(DEPTH));
    assign level_out = level;

    // Accept/drop decisions use pre-cycle flags; clear discards everything in its cycle.
    assign wr_acc = data_valid_in && !full_out && !clear_in;
    assign rd_acc = rd_en_in && !empty_out && !clear_in;
    assign drop   = data_valid_in && full_out && !clear_in;

    always_comb begin
        level_nxt = level;
        if (wr_acc && !rd_acc) begin
            level_nxt = level + LW'(1);
        end else if (rd_acc && !wr_acc) begin
            level_nxt = level - LW'(1);
        end
    end

    // Storage is not reset or cleared; only pointers and level define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            rd_data_out  <= '0;
            rd_valid_out <= 1'b0;
            irq_out      <= 1'b0;
            overflow_out <= 1'b0;
            drop_cnt_out <= '0;
        end else begin
            irq_out      <= (threshold_in != '0) && (level >= threshold_in);
            rd_valid_out <= rd_acc;
            if (clear_in) begin
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                level        <= '0;
                overflow_out <= 1'b0;
                drop_cnt_out <= '0;
            end else begin
                level <= level_nxt;
                if (wr_acc) begin
                    wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
                end
                if (rd_acc) begin
                    rd_ptr      <= rd_ptr + DEPTH_LOG2'(1);
                    rd_data_out <= mem[rd_ptr];
                end
                if (drop) begin
                    overflow_out <= 1'b1;
                    if (drop_cnt_out != {CW{1'b1}}) begin
                        drop_cnt_out <= drop_cnt_out + CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Self-checking bench for adc_sample_fifo: queue-based reference model, one task per scenario.
module tb_adc_sample_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_in = '0;
    logic        data_valid_in = 1'b0;
    logic        rd_en_in = 1'b0;
    logic        clear_in = 1'b0;
    logic [4:0]  threshold_in = '0;
    logic [31:0] rd_data_out;
    logic        rd_valid_out;
    logic        empty_out;
    logic        full_out;
    logic [4:0]  level_out;
    logic        irq_out;
    logic        overflow_out;
    logic [15:0] drop_cnt_out;

    adc_sample_fifo #(.DATA_WIDTH(32), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid_in(data_valid_in),
        .rd_en_in(rd_en_in), .clear_in(clear_in), .threshold_in(threshold_in),
        .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .empty_out(empty_out),
        .full_out(full_out), .level_out(level_out), .irq_out(irq_out),
        .overflow_out(overflow_out), .drop_cnt_out(drop_cnt_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents as a queue, plus expected registered outputs
    logic [31:0] m_q [$];
    logic [31:0] m_rd = '0;
    logic        m_rv = 1'b0;
    logic        m_irq = 1'b0;
    logic        m_ovf = 1'b0;
    int          m_drops = 0;

    task automatic model_reset();
        m_q.delete(); m_rd = '0; m_rv = 1'b0; m_irq = 1'b0; m_ovf = 1'b0; m_drops = 0;
    endtask

    // Drive one cycle of inputs, advance the model on the same edge, settle 1 time unit
    task automatic tick(input logic v, input logic [31:0] d, input logic r, input logic c);
        int sz;
        data_valid_in = v; data_in = d; rd_en_in = r; clear_in = c;
        @(posedge clk);
        sz = m_q.size();
        m_irq = (threshold_in != 0) && (sz >= int'(threshold_in));
        if (c) begin
            m_q.delete(); m_ovf = 1'b0; m_drops = 0; m_rv = 1'b0;
        end else begin
            if (r && sz > 0) begin m_rd = m_q.pop_front(); m_rv = 1'b1; end
            else m_rv = 1'b0;
            if (v && sz < 16) m_q.push_back(d);
            else if (v) begin m_ovf = 1'b1; if (m_drops < 65535) m_drops++; end
        end
        #1;
        data_valid_in = 1'b0; rd_en_in = 1'b0; clear_in = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, $urandom, i == 3, 1'b0);
        #3 rst = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (level_out !== 5'd0) begin n_bad++; $display("FAIL rst_level got %0d want 0", level_out); end
        n_cmp++; if (empty_out !== 1'b1 || full_out !== 1'b0) begin n_bad++; $display("FAIL rst_flags got e=%b f=%b want e=1 f=0", empty_out, full_out); end
        n_cmp++; if (rd_valid_out !== 1'b0 || rd_data_out !== 32'd0) begin n_bad++; $display("FAIL rst_rd got v=%b d=%h want 0", rd_valid_out, rd_data_out); end
        n_cmp++; if (irq_out !== 1'b0 || overflow_out !== 1'b0 || drop_cnt_out !== 16'd0) begin n_bad++; $display("FAIL rst_status got irq=%b ovf=%b drops=%0d want 0", irq_out, overflow_out, drop_cnt_out); end
        #2 rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, '0, 1'b0, 1'b0);
            n_cmp++;
            if (level_out !== 5'd0 || empty_out !== 1'b1 || rd_valid_out !== 1'b0 || rd_data_out !== 32'd0 || overflow_out !== 1'b0 || drop_cnt_out !== 16'd0 || irq_out !== 1'b0) begin
                n_bad++; $display("FAIL rst_idle cycle %0d got lvl=%0d e=%b v=%b d=%h want idle reset state", i, level_out, empty_out, rd_valid_out, rd_data_out);
            end
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) tick(1'b1, 32'h1000 + 32'(i), 1'b0, 1'b0);
        n_cmp++; if (level_out !== 5'd16 || full_out !== 1'b1 || empty_out !== 1'b0) begin n_bad++; $display("FAIL fill got lvl=%0d f=%b e=%b want 16/1/0", level_out, full_out, empty_out); end
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, '0, 1'b1, 1'b0);
            n_cmp++;
            if (rd_valid_out !== 1'b1 || rd_data_out !== 32'h1000 + 32'(i)) begin
                n_bad++; $display("FAIL drain[%0d] got v=%b d=%h want v=1 d=%h", i, rd_valid_out, rd_data_out, 32'h1000 + 32'(i));
            end
        end
        n_cmp++; if (empty_out !== 1'b1 || level_out !== 5'd0) begin n_bad++; $display("FAIL drain_end got e=%b lvl=%0d want 1/0", empty_out, level_out); end
        tick(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL drain_pulse got v=%b want 0", rd_valid_out); end
    endtask

    task automatic test_overflow();
        logic [31:0] oldest;
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        oldest = m_q[0];
        tick(1'b1, $urandom, 1'b0, 1'b0);
        tick(1'b0, '0, 1'b0, 1'b0);
        tick(1'b1, $urandom, 1'b0, 1'b0);
        tick(1'b1, $urandom, 1'b1, 1'b0);
        n_cmp++; if (overflow_out !== 1'b1 || drop_cnt_out !== 16'd3) begin n_bad++; $display("FAIL ovf3 got ovf=%b drops=%0d want 1/3", overflow_out, drop_cnt_out); end
        n_cmp++; if (rd_valid_out !== 1'b1 || rd_data_out !== oldest) begin n_bad++; $display("FAIL ovf_read got v=%b d=%h want 1/%h", rd_valid_out, rd_data_out, oldest); end
        n_cmp++; if (level_out !== 5'd15) begin n_bad++; $display("FAIL ovf_level got %0d want 15", level_out); end
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 65535; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        n_cmp++; if (drop_cnt_out !== 16'hFFFF) begin n_bad++; $display("FAIL sat_reach got %h want ffff", drop_cnt_out); end
        for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        n_cmp++; if (drop_cnt_out !== 16'hFFFF || drop_cnt_out !== 16'(m_drops)) begin n_bad++; $display("FAIL sat_hold got %h want ffff", drop_cnt_out); end
        n_cmp++; if (overflow_out !== 1'b1 || level_out !== 5'd16) begin n_bad++; $display("FAIL sat_state got ovf=%b lvl=%0d want 1/16", overflow_out, level_out); end
    endtask

    task automatic test_empty();
        tick(1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (rd_valid_out !== 1'b0 || rd_data_out !== m_rd) begin n_bad++; $display("FAIL empty_rd got v=%b d=%h want 0/%h", rd_valid_out, rd_data_out, m_rd); end
        tick(1'b1, 32'hCAFE_0001, 1'b1, 1'b0);
        n_cmp++; if (level_out !== 5'd1 || rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL empty_wr_rd got lvl=%0d v=%b want 1/0", level_out, rd_valid_out); end
        n_cmp++; if (rd_data_out !== m_rd) begin n_bad++; $display("FAIL empty_hold got %h want %h", rd_data_out, m_rd); end
        tick(1'b0, '0, 1'b1, 1'b0);
        n_cmp++; if (rd_valid_out !== 1'b1 || rd_data_out !== 32'hCAFE_0001) begin n_bad++; $display("FAIL empty_after got v=%b d=%h want 1/cafe0001", rd_valid_out, rd_data_out); end
    endtask

    task automatic test_wrap();
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, $urandom, 1'b1, 1'b0);
            n_cmp++;
            if (level_out !== 5'd5 || rd_valid_out !== 1'b1 || rd_data_out !== m_rd) begin
                n_bad++; $display("FAIL wrap[%0d] got lvl=%0d v=%b d=%h want 5/1/%h", i, level_out, rd_valid_out, rd_data_out, m_rd);
            end
        end
    endtask

    task automatic test_clear_irq();
        tick(1'b0, '0, 1'b0, 1'b1);
        threshold_in = 5'd8;
        for (int i = 0; i < 8; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        n_cmp++; if (level_out !== 5'd8 || irq_out !== 1'b0) begin n_bad++; $display("FAIL irq_lag got lvl=%0d irq=%b want 8/0", level_out, irq_out); end
        tick(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (irq_out !== 1'b1) begin n_bad++; $display("FAIL irq_set got %b want 1", irq_out); end
        for (int i = 0; i < 9; i++) tick(1'b1, $urandom, 1'b0, 1'b0);
        n_cmp++; if (overflow_out !== 1'b1 || drop_cnt_out !== 16'd1) begin n_bad++; $display("FAIL pre_clear got ovf=%b drops=%0d want 1/1", overflow_out, drop_cnt_out); end
        tick(1'b1, $urandom, 1'b1, 1'b1);
        n_cmp++; if (level_out !== 5'd0 || empty_out !== 1'b1 || rd_valid_out !== 1'b0) begin n_bad++; $display("FAIL clear got lvl=%0d e=%b v=%b want 0/1/0", level_out, empty_out, rd_valid_out); end
        n_cmp++; if (overflow_out !== 1'b0 || drop_cnt_out !== 16'd0 || rd_data_out !== m_rd) begin n_bad++; $display("FAIL clear_status got ovf=%b drops=%0d d=%h want 0/0/%h", overflow_out, drop_cnt_out, rd_data_out, m_rd); end
        tick(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL clear_irq got %b want 0", irq_out); end
        threshold_in = 5'd0;
        for (int i = 0; i < 18; i++) begin
            tick(i < 16, $urandom, 1'b0, 1'b0);
            n_cmp++; if (irq_out !== 1'b0) begin n_bad++; $display("FAIL irq_off[%0d] got %b want 0", i, irq_out); end
        end
    endtask

    task automatic test_random();
        tick(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) threshold_in = 5'($urandom_range(0, 16));
            tick($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
            n_cmp++;
            if (level_out !== 5'(m_q.size()) || empty_out !== (m_q.size() == 0) || full_out !== (m_q.size() == 16) ||
                rd_valid_out !== m_rv || rd_data_out !== m_rd || irq_out !== m_irq ||
                overflow_out !== m_ovf || drop_cnt_out !== 16'(m_drops)) begin
                n_bad++;
                $display("FAIL rand[%0d] got lvl=%0d v=%b d=%h irq=%b ovf=%b drops=%0d want lvl=%0d v=%b d=%h irq=%b ovf=%b drops=%0d",
                         i, level_out, rd_valid_out, rd_data_out, irq_out, overflow_out, drop_cnt_out,
                         m_q.size(), m_rv, m_rd, m_irq, m_ovf, m_drops);
            end
        end
    endtask

    initial begin
        model_reset();
        #12 rst = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_empty();
        test_wrap();
        test_clear_irq();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adc_sample_fifo.md
# adc_sample_fifo

Sample buffer directly downstream of the VCO-ADC core. It captures each 32-bit decimated word presented with `data_valid_out` and stores it in a synchronous FIFO, so that a slower host-side reader (Wishbone/logic-analyzer glue) can drain samples at its own pace. It reports fill level, a threshold interrupt, and sticky overflow status with a saturating drop counter.

## Interface

Parameters:
- `DATA_WIDTH`, 32: sample width; matches the ADC `data_out` width.
- `DEPTH_LOG2`, 4: log2 of FIFO depth. Depth is 16 entries at the default.

Ports:
- `clk` input 1: single clock, same domain as the ADC core.
- `rst` input 1: reset, asynchronous, active-low.
- `data_in` input DATA_WIDTH: sample word from the ADC `data_out`.
- `data_valid_in` input 1: write strobe from the ADC `data_valid_out`, one cycle per sample.
- `rd_en_in` input 1: read request from the host.
- `clear_in` input 1: synchronous flush.
- `threshold_in` input DEPTH_LOG2+1: interrupt level. A value of 0 disables the interrupt.
- `rd_data_out` output DATA_WIDTH: read data, registered.
- `rd_valid_out` output 1: one-cycle pulse marking new `rd_data_out`.
- `empty_out` output 1: level == 0.
- `full_out` output 1: level == 2^DEPTH_LOG2.
- `level_out` output DEPTH_LOG2+1: current occupancy, registered.
- `irq_out` output 1: level >= threshold_in, registered.
- `overflow_out` output 1: sticky flag, set when a sample is dropped.
- `drop_cnt_out` output 16: count of dropped samples, saturating.

## Operation

**Storage**
- Register array of 2^DEPTH_LOG2 entries.
- Write and read pointers are DEPTH_LOG2 bits wide and wrap naturally modulo depth.
- Occupancy counter `level` is DEPTH_LOG2+1 bits.

**Write**
- Accepted when `data_valid_in` = 1 and `full_out` = 0, using pre-cycle state. The word is stored at the write pointer and the pointer increments.

**Overflow**
- A write with `full_out` = 1 is dropped. This holds even if a read occurs in the same cycle, because full is evaluated on pre-cycle state.
- On a drop, `overflow_out` is set, and `drop_cnt_out` increments, saturating at 16'hFFFF.

**Read**
- Accepted when `rd_en_in` = 1 and `empty_out` = 0, using pre-cycle state.
- The entry at the read pointer is loaded into `rd_data_out`, the pointer increments, and `rd_valid_out` = 1 on the next cycle.

**Underflow**
- `rd_en_in` with `empty_out` = 1 is ignored: `rd_valid_out` = 0 and `rd_data_out` holds.
- There is no fall-through. A write and a read in the same cycle to an empty FIFO performs the write only.

**Simultaneous accepted read and write**
- Both pointers advance and `level` is unchanged. This applies at any non-empty, non-full level, including the write pointer wrapping past the read pointer index.

**Level update**
- `level` = level + accepted_write − accepted_read.

**Clear**
- `clear_in` = 1 resets both pointers, `level`, `overflow_out` and `drop_cnt_out` to 0.
- It has priority over any same-cycle write or read; both are discarded and not counted as drops.
- `rd_valid_out` = 0 that cycle and `rd_data_out` holds. Storage contents are not cleared.

**Interrupt**
- `irq_out` = (threshold_in != 0) && (level >= threshold_in), evaluated on the registered level.

**Reset**
- All pointers, `level`, `rd_data_out`, `rd_valid_out`, `irq_out`, `overflow_out` and `drop_cnt_out` are 0.
- `empty_out` = 1 and `full_out` = 0.
- Reset asserted mid-operation takes effect immediately (asynchronous) and discards all pending state.

## Timing

- **Write to visibility:** a sample written in cycle N is reflected in `level_out`, `empty_out` and `full_out` in cycle N+1. It becomes readable by an `rd_en_in` in cycle N+1 or later.
- **Read latency:** `rd_en_in` in cycle N gives `rd_data_out` and `rd_valid_out` in cycle N+1.
- **Back-to-back reads:** one read per cycle is supported while non-empty.
- **Flag derivation:**
  - `empty_out` and `full_out` are combinational from the registered `level` only; there are no paths from inputs to outputs.
  - `irq_out` lags `level_out` by one cycle.
- **Overflow flags:** `overflow_out` and `drop_cnt_out` update in the cycle after the dropped write.
- **Throughput:** ADC valid pulses arrive at most once per oversample period, and the FIFO accepts one write per cycle.

## Test plan

- **Reset values:** drive `rst` = 0 asynchronously mid-cycle → all outputs 0 and `empty_out` = 1 immediately; release and idle 5 cycles → no change.
- **Fill and drain:** write 16 samples 0x1000+i → `level_out` = 16, `full_out` = 1. Read 16 back-to-back → `rd_data_out` = 0x1000..0x100F in order, one cycle after each `rd_en_in`. End state: `empty_out` = 1 and `level_out` = 0.
- **Overflow:**
  - With the FIFO full, pulse `data_valid_in` 3 times (once with concurrent `rd_en_in`) → `overflow_out` = 1 and `drop_cnt_out` = 3. The concurrent read still returns the oldest entry.
  - Force 65540 drops → `drop_cnt_out` = 0xFFFF.
- **Empty corner cases:**
  - `rd_en_in` on empty → no `rd_valid_out`, `rd_data_out` holds.
  - Simultaneous write and read on empty → `level_out` = 1 and no `rd_valid_out`.
- **Wrap-around:** with `level_out` held at 5, perform 40 cycles of simultaneous read and write → `level_out` stays 5 and data emerges in FIFO order across pointer wrap.
- **Clear and irq:**
  - `threshold_in` = 8: write 8 → `irq_out` = 1 one cycle after `level_out` = 8.
  - Assert `clear_in` together with `data_valid_in` and `rd_en_in` → `level_out` = 0, `irq_out` = 0 next cycle, `overflow_out` and `drop_cnt_out` = 0, no `rd_valid_out`.
  - `threshold_in` = 0 → `irq_out` never asserts.
